// File: rtl/i2c_arb_pkg.sv
// Shared constants for the I2C APB round-robin arbiter: FSM encoding,
// default sizing and the owner-index width helper.
package i2c_arb_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_OWN  = 2'd1;
   localparam logic [1:0] ST_REL  = 2'd2;

   localparam int NREQ_DEF    = 4;
   localparam int TIMEOUT_DEF = 1024;

   function automatic int idx_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/i2c_rr_picker.sv
// Combinational round-robin pick: first set request searching upward from
// the pointer with wrap-around, returned one-hot with a valid flag.
module i2c_rr_picker
   import i2c_arb_pkg::*;
#(
   parameter int NREQ = NREQ_DEF,
   localparam int IW  = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [IW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_pick,
   output logic            o_valid
);

   int            w_sum;
   logic [IW-1:0] w_idx;

   // Walk from the farthest offset down so the closest hit to the pointer wins.
   always_comb begin
      o_pick  = '0;
      o_valid = |i_req;
      w_sum   = 0;
      w_idx   = '0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         w_sum = int'(i_ptr) + i;
         if (w_sum >= NREQ) w_sum = w_sum - NREQ;
         w_idx = IW'(w_sum);
         if (i_req[w_idx]) begin
            o_pick        = '0;
            o_pick[w_idx] = 1'b1;
         end
      end
   end

endmodule

// File: rtl/i2c_apb_arbiter.sv
// Round-robin owner arbiter sharing the i2c_top APB slave between masters.
// Optional idle-ownership timeout is enabled with `define I2C_ARB_TIMEOUT_EN.
module i2c_apb_arbiter
   import i2c_arb_pkg::*;
#(
   parameter int NREQ    = NREQ_DEF,
   parameter int TIMEOUT = TIMEOUT_DEF,
   localparam int IW     = idx_w(NREQ)
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic [NREQ-1:0]   req,
   output logic [NREQ-1:0]   gnt,
   input  logic [NREQ-1:0]   s_psel,
   input  logic [NREQ-1:0]   s_penable,
   input  logic [NREQ-1:0]   s_pwrite,
   input  logic [8*NREQ-1:0] s_paddr,
   input  logic [8*NREQ-1:0] s_pwdata,
   output logic [7:0]        s_prdata,
   output logic              m_psel,
   output logic              m_penable,
   output logic              m_pwrite,
   output logic [7:0]        m_paddr,
   output logic [7:0]        m_pwdata,
   input  logic [7:0]        m_prdata,
   output logic              busy,
   output logic [IW-1:0]     owner,
   output logic              timeout_pulse
);

   logic [1:0]      r_state;
   logic [NREQ-1:0] r_gnt;
   logic [IW-1:0]   r_ptr;
   logic [IW-1:0]   r_owner;

   logic            w_own;
   logic [IW-1:0]   w_next_ptr;
   logic [IW-1:0]   w_pick_ptr;
   logic [NREQ-1:0] w_req_eff;
   logic [NREQ-1:0] w_pick;
   logic            w_valid;
   logic [IW-1:0]   w_pick_idx;
   logic            w_rel;
   logic            w_force;

   assign w_own      = (r_state == ST_OWN);
   assign w_next_ptr = (r_owner == IW'(NREQ - 1)) ? '0 : r_owner + 1'b1;
   // RELEASE arbitrates with the already-advanced pointer in the same cycle.
   assign w_pick_ptr = (r_state == ST_REL) ? w_next_ptr : r_ptr;
   assign w_rel      = w_own && !req[r_owner] && !m_psel;

   assign m_psel    = w_own & s_psel[r_owner];
   assign m_penable = w_own & s_penable[r_owner];
   assign m_pwrite  = w_own & s_pwrite[r_owner];
   assign m_paddr   = w_own ? s_paddr[{r_owner, 3'b000} +: 8]  : 8'h00;
   assign m_pwdata  = w_own ? s_pwdata[{r_owner, 3'b000} +: 8] : 8'h00;
   assign s_prdata  = m_prdata;

   assign gnt   = r_gnt;
   assign busy  = w_own;
   assign owner = r_owner;

`ifdef I2C_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT + 1);

   logic [CW-1:0]   r_cnt;
   logic [NREQ-1:0] r_blk;
   logic            r_tpulse;

   // A timed-out owner stays masked until it lets go of req once.
   assign w_req_eff     = req & ~r_blk;
   assign w_force       = w_own && !w_rel && !m_psel && (r_cnt == CW'(TIMEOUT - 1));
   assign timeout_pulse = r_tpulse;

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_cnt    <= '0;
         r_blk    <= '0;
         r_tpulse <= 1'b0;
      end else begin
         r_cnt    <= (!w_own || m_psel) ? '0 : r_cnt + 1'b1;
         r_blk    <= (r_blk & req) | (w_force ? r_gnt : '0);
         r_tpulse <= w_force;
      end
   end
`else
   logic w_unused_timeout;

   assign w_req_eff        = req;
   assign w_force          = 1'b0;
   assign timeout_pulse    = 1'b0;
   assign w_unused_timeout = ^TIMEOUT;
`endif

   i2c_rr_picker #(.NREQ(NREQ)) u_picker (
      .i_req   (w_req_eff),
      .i_ptr   (w_pick_ptr),
      .o_pick  (w_pick),
      .o_valid (w_valid)
   );

   always_comb begin
      w_pick_idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_pick[i]) w_pick_idx = IW'(i);
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         r_state <= ST_IDLE;
         r_gnt   <= '0;
         r_ptr   <= '0;
         r_owner <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_valid) begin
                  r_state <= ST_OWN;
                  r_gnt   <= w_pick;
                  r_owner <= w_pick_idx;
               end
            end
            ST_OWN: begin
               if (w_rel || w_force) begin
                  r_state <= ST_REL;
                  r_gnt   <= '0;
               end
            end
            ST_REL: begin
               r_ptr <= w_next_ptr;
               if (w_valid) begin
                  r_state <= ST_OWN;
                  r_gnt   <= w_pick;
                  r_owner <= w_pick_idx;
               end else begin
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_apb_arbiter.sv
// Directed self-checking bench for i2c_apb_arbiter (NREQ=4, TIMEOUT=16).
module tb_i2c_apb_arbiter;

   localparam int NREQ = 4;

   logic              PCLK;
   logic              PRESET;
   logic [NREQ-1:0]   req;
   logic [NREQ-1:0]   gnt;
   logic [NREQ-1:0]   s_psel;
   logic [NREQ-1:0]   s_penable;
   logic [NREQ-1:0]   s_pwrite;
   logic [8*NREQ-1:0] s_paddr;
   logic [8*NREQ-1:0] s_pwdata;
   logic [7:0]        s_prdata;
   logic              m_psel;
   logic              m_penable;
   logic              m_pwrite;
   logic [7:0]        m_paddr;
   logic [7:0]        m_pwdata;
   logic [7:0]        m_prdata;
   logic              busy;
   logic [1:0]        owner;
   logic              timeout_pulse;

   int total;
   int bad;

   i2c_apb_arbiter #(.NREQ(NREQ), .TIMEOUT(16)) dut (
      .PCLK          (PCLK),
      .PRESET        (PRESET),
      .req           (req),
      .gnt           (gnt),
      .s_psel        (s_psel),
      .s_penable     (s_penable),
      .s_pwrite      (s_pwrite),
      .s_paddr       (s_paddr),
      .s_pwdata      (s_pwdata),
      .s_prdata      (s_prdata),
      .m_psel        (m_psel),
      .m_penable     (m_penable),
      .m_pwrite      (m_pwrite),
      .m_paddr       (m_paddr),
      .m_pwdata      (m_pwdata),
      .m_prdata      (m_prdata),
      .busy          (busy),
      .owner         (owner),
      .timeout_pulse (timeout_pulse)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;

   // Inputs change and outputs are observed 1 time unit after each rising edge.
   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   task automatic clear_apb();
      s_psel    = '0;
      s_penable = '0;
      s_pwrite  = '0;
      s_paddr   = '0;
      s_pwdata  = '0;
   endtask

   task automatic do_reset();
      PRESET = 1'b1;
      req    = '0;
      clear_apb();
      step();
      step();
      PRESET = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 || timeout_pulse !== 1'b0) begin
         bad++;
         $display("FAIL reset_ctrl: gnt=%b busy=%b owner=%0d tp=%b, want 0000 0 0 0", gnt, busy, owner, timeout_pulse);
      end
      s_psel[2]        = 1'b1;
      s_penable[2]     = 1'b1;
      s_pwrite[2]      = 1'b1;
      s_paddr[23:16]   = 8'h11;
      s_pwdata[23:16]  = 8'h22;
      #1;
      total++;
      if ({m_psel, m_penable, m_pwrite, m_paddr, m_pwdata} !== 19'd0) begin
         bad++;
         $display("FAIL reset_mbus: psel=%b pen=%b pw=%b addr=%h wdata=%h, want all 0", m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
      end
      step();
      total++;
      if (m_psel !== 1'b0 || gnt !== 4'b0000) begin
         bad++;
         $display("FAIL reset_nonowner: m_psel=%b gnt=%b, want 0 0000", m_psel, gnt);
      end
      clear_apb();
   endtask

   task automatic test_single_owner();
      req = 4'b0010;
      step();
      total++;
      if (gnt !== 4'b0010 || busy !== 1'b1 || owner !== 2'd1) begin
         bad++;
         $display("FAIL single_grant: gnt=%b busy=%b owner=%0d, want 0010 1 1", gnt, busy, owner);
      end
      // Write setup phase by requester 1; requester 3 tries to sneak in.
      s_psel[1] = 1'b1; s_pwrite[1] = 1'b1;
      s_paddr[15:8] = 8'h04; s_pwdata[15:8] = 8'h5A;
      s_psel[3] = 1'b1; s_paddr[31:24] = 8'hEE; s_pwdata[31:24] = 8'h99;
      #1;
      total++;
      if (m_psel !== 1'b1 || m_penable !== 1'b0 || m_pwrite !== 1'b1 || m_paddr !== 8'h04 || m_pwdata !== 8'h5A) begin
         bad++;
         $display("FAIL write_setup: psel=%b pen=%b pw=%b addr=%h wd=%h, want 1 0 1 04 5a", m_psel, m_penable, m_pwrite, m_paddr, m_pwdata);
      end
      step();
      s_penable[1] = 1'b1;
      #1;
      total++;
      if (m_psel !== 1'b1 || m_penable !== 1'b1 || m_paddr !== 8'h04 || m_pwdata !== 8'h5A) begin
         bad++;
         $display("FAIL write_access: psel=%b pen=%b addr=%h wd=%h, want 1 1 04 5a", m_psel, m_penable, m_paddr, m_pwdata);
      end
      step();
      s_psel[1] = 1'b0; s_penable[1] = 1'b0;
      #1;
      total++;
      if (m_psel !== 1'b0) begin
         bad++;
         $display("FAIL nonowner_ignored: m_psel=%b, want 0", m_psel);
      end
      s_psel[1] = 1'b1; s_pwrite[1] = 1'b0; s_paddr[15:8] = 8'h08;
      m_prdata = 8'hC3;
      #1;
      total++;
      if (m_psel !== 1'b1 || m_pwrite !== 1'b0 || m_paddr !== 8'h08 || s_prdata !== 8'hC3) begin
         bad++;
         $display("FAIL read: psel=%b pw=%b addr=%h prdata=%h, want 1 0 08 c3", m_psel, m_pwrite, m_paddr, s_prdata);
      end
      step();
      clear_apb();
      req = 4'b0000;
      step();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd1) begin
         bad++;
         $display("FAIL single_release: gnt=%b busy=%b owner=%0d, want 0000 0 1", gnt, busy, owner);
      end
      step();
   endtask

   task automatic test_round_robin();
      int e;
      logic [NREQ-1:0] want;
      do_reset();
      req = 4'b1111;
      step();
      total++;
      if (gnt !== 4'b0001) begin
         bad++;
         $display("FAIL rr_first: gnt=%b, want 0001", gnt);
      end
      for (int n = 0; n < 4; n++) begin
         e = n;
         s_psel[e] = 1'b1; s_pwrite[e] = 1'b1;
         step();
         s_penable[e] = 1'b1;
         step();
         clear_apb();
         req[e] = 1'b0;
         step();
         total++;
         if (gnt !== 4'b0000 || busy !== 1'b0) begin
            bad++;
            $display("FAIL rr_gap%0d: gnt=%b busy=%b, want 0000 0", n, gnt, busy);
         end
         req[e] = 1'b1;
         step();
         want = '0;
         want[(e + 1) % NREQ] = 1'b1;
         total++;
         if (gnt !== want || owner !== 2'((e + 1) % NREQ)) begin
            bad++;
            $display("FAIL rr_next%0d: gnt=%b owner=%0d, want %b %0d", n, gnt, owner, want, (e + 1) % NREQ);
         end
      end
      req = '0;
      step();
      step();
   endtask

   task automatic test_drop_in_transfer();
      do_reset();
      req = 4'b0100;
      step();
      s_psel[2] = 1'b1; s_pwrite[2] = 1'b1;
      req = 4'b0000;
      step();
      total++;
      if (gnt !== 4'b0100 || m_psel !== 1'b1) begin
         bad++;
         $display("FAIL hold_setup: gnt=%b m_psel=%b, want 0100 1", gnt, m_psel);
      end
      s_penable[2] = 1'b1;
      step();
      total++;
      if (gnt !== 4'b0100 || busy !== 1'b1) begin
         bad++;
         $display("FAIL hold_access: gnt=%b busy=%b, want 0100 1", gnt, busy);
      end
      clear_apb();
      step();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
         bad++;
         $display("FAIL drop_release: gnt=%b busy=%b, want 0000 0", gnt, busy);
      end
      step();
   endtask

   task automatic test_reset_mid_transfer();
      // Pointer is 3 here, left over from the previous owner 2.
      req = 4'b0100;
      step();
      total++;
      if (gnt !== 4'b0100) begin
         bad++;
         $display("FAIL mid_grant: gnt=%b, want 0100", gnt);
      end
      s_psel[2] = 1'b1; s_pwrite[2] = 1'b1; s_paddr[23:16] = 8'h33; s_pwdata[23:16] = 8'h44;
      step();
      s_penable[2] = 1'b1;
      PRESET = 1'b1;
      step();
      total++;
      if (gnt !== 4'b0000 || busy !== 1'b0 || owner !== 2'd0 ||
          {m_psel, m_penable, m_pwrite, m_paddr, m_pwdata} !== 19'd0) begin
         bad++;
         $display("FAIL mid_reset: gnt=%b busy=%b owner=%0d psel=%b pen=%b addr=%h, want all 0", gnt, busy, owner, m_psel, m_penable, m_paddr);
      end
      PRESET = 1'b0;
      clear_apb();
      req = 4'b1100;
      step();
      total++;
      if (gnt !== 4'b0100) begin
         bad++;
         $display("FAIL mid_ptr: gnt=%b, want 0100", gnt);
      end
      req = '0;
      step();
      step();
   endtask

   task automatic test_timeout();
`ifdef I2C_ARB_TIMEOUT_EN
      int hits;
      do_reset();
      req = 4'b0011;
      step();
      hits = 0;
      for (int i = 0; i < 15; i++) begin
         step();
         if (timeout_pulse !== 1'b0 || gnt !== 4'b0001) hits++;
      end
      total++;
      if (hits != 0) begin
         bad++;
         $display("FAIL tmo_early: %0d bad cycles before timeout, want 0", hits);
      end
      step();
      total++;
      if (timeout_pulse !== 1'b1 || gnt !== 4'b0000) begin
         bad++;
         $display("FAIL tmo_fire: tp=%b gnt=%b, want 1 0000", timeout_pulse, gnt);
      end
      step();
      total++;
      if (timeout_pulse !== 1'b0 || gnt !== 4'b0010) begin
         bad++;
         $display("FAIL tmo_next: tp=%b gnt=%b, want 0 0010", timeout_pulse, gnt);
      end
      req[1] = 1'b0;
      step();
      step();
      total++;
      if (gnt !== 4'b0000) begin
         bad++;
         $display("FAIL tmo_block: gnt=%b, want 0000", gnt);
      end
      req[0] = 1'b0;
      step();
      req[0] = 1'b1;
      step();
      total++;
      if (gnt !== 4'b0001) begin
         bad++;
         $display("FAIL tmo_regrant: gnt=%b, want 0001", gnt);
      end
      req = '0;
      step();
      step();
`else
      int hits;
      do_reset();
      req = 4'b0001;
      step();
      hits = 0;
      for (int i = 0; i < 20; i++) begin
         step();
         if (timeout_pulse !== 1'b0 || gnt !== 4'b0001) hits++;
      end
      total++;
      if (hits != 0) begin
         bad++;
         $display("FAIL no_timeout: %0d cycles lost grant or pulsed, want 0", hits);
      end
      req = '0;
      step();
      step();
`endif
   endtask

   initial begin
      total    = 0;
      bad      = 0;
      PRESET   = 1'b1;
      req      = '0;
      m_prdata = 8'h00;
      clear_apb();
      test_reset();
      test_single_owner();
      test_round_robin();
      test_drop_in_transfer();
      test_reset_mid_transfer();
      test_timeout();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/i2c_apb_arbiter.md
# i2c_apb_arbiter

Round-robin arbiter sharing the single APB slave port of the I2C subsystem between several bus masters (CPU, DMA, housekeeping sequencer). Sits directly in front of `i2c_top`. It grants one requester at a time and forwards that requester's APB transfers unchanged. It holds the grant for a whole multi-transfer I2C transaction (configure, load data, start, poll status, read data) so transactions from different masters never interleave.

## Interface
Parameters:
- `NREQ`, 4, number of requesters (2..8)
- `TIMEOUT`, 1024, idle cycles in ownership before forced release (used only with the timeout feature)

Ports:
- `PCLK` in 1: single clock, all logic on rising edge
- `PRESET` in 1: reset, synchronous, active-high
- `req` in NREQ: per-requester ownership request, level
- `gnt` out NREQ: one-hot grant, registered
- `s_psel`, `s_penable`, `s_pwrite` in NREQ each: per-requester APB controls
- `s_paddr`, `s_pwdata` in 8*NREQ: per-requester APB address/data; requester i occupies bits [8i+7:8i]
- `s_prdata` out 8: read data, broadcast to all requesters
- `m_psel`, `m_penable`, `m_pwrite` out 1 each: APB to `i2c_top`
- `m_paddr`, `m_pwdata` out 8 each: APB to `i2c_top`
- `m_prdata` in 8: from `i2c_top` `PRDATA`
- `busy` out 1: a grant is active
- `owner` out clog2(NREQ): index of current or last owner
- `timeout_pulse` out 1: one-cycle pulse on forced release

## Operation
- States: IDLE, OWN, RELEASE.
- **IDLE**, any `req` set: pick the first set bit searching upward from `ptr` with wrap, i.e. ptr, ptr+1, ..., NREQ-1, 0, ... Go to OWN. Set `gnt` one-hot to that bit and set `owner`.
- **OWN**:
  - `m_*` outputs are a combinational mux of the owner's `s_*` inputs.
  - `s_psel` from non-owners is ignored. Their transfers are not forwarded and not acknowledged.
  - `s_prdata = m_prdata` at all times.
- **OWN → RELEASE**: taken when the owner's `req` is 0 and `m_psel` is 0. If `req` drops during an APB transfer (`m_psel` = 1), the grant is held until `m_psel` returns to 0.
- **RELEASE**, one cycle:
  - `gnt` = 0 and `m_psel` = 0.
  - `ptr` ← (owner+1) mod NREQ.
  - Go to OWN (arbitrate as in IDLE using the new `ptr`) if any `req` is set, otherwise go to IDLE.
- A requester that reasserts `req` immediately after release is considered only after the others, because of the pointer advance.
- **Reset values**:
  - state IDLE; `gnt` 0; `ptr` 0; `owner` 0; `busy` 0; `timeout_pulse` 0.
  - `m_psel`, `m_penable`, `m_pwrite` are 0; `m_paddr` and `m_pwdata` are 0.
  - A reset during OWN drops the grant at that edge. No APB transfer is completed.
- **Outside OWN**: all `m_*` outputs are driven to 0.

## Timing
- Grant latency: `req` first sampled high at edge k in IDLE → `gnt` high after edge k, i.e. a 1-cycle latency.
- Handover: owner `req` sampled low at edge k (bus idle) → RELEASE after k. If another `req` is pending, next `gnt` is high after k+1. The grant gap is exactly one cycle.
- APB forwarding adds zero latency. A transfer is two cycles (setup with `psel`, then access with `psel`+`penable`), matching the `i2c_top` slave.
- `busy` = (state == OWN). `busy` is registered together with `gnt`.
- Requests arriving simultaneously in IDLE are resolved by `ptr`. After reset, index 0 has the highest priority.

## Configuration
- `I2C_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to OWN and on every cycle with `m_psel` = 1, and increments on every other OWN cycle.
  - When it reaches `TIMEOUT`, go to RELEASE regardless of `req` and pulse `timeout_pulse` for one cycle.
  - The timed-out owner must deassert `req` before it can be granted again.
- Undefined: no counter is present, `timeout_pulse` is tied to 0, and ownership lasts until `req` drops.

## Structure
- Package `i2c_arb_pkg`: state encoding (IDLE, OWN, RELEASE), the default `NREQ` and `TIMEOUT` constants, and the owner index width function.
- Sub-module `i2c_rr_picker`: combinational, inputs `req` and `ptr`, outputs a one-hot pick and a valid flag. It is instantiated once, used in both IDLE and RELEASE.

## Test plan
- Reset with all `req` = 0 → `gnt` = 0, `busy` = 0, all `m_*` = 0; an `s_psel` pulse on requester 2 is not forwarded.
- `req[1]` rises alone → `gnt` = 0010 one cycle later. A write of 0x5A to addr 0x04 by requester 1 appears on `m_paddr`/`m_pwdata` in the same cycles. A read returns `m_prdata` = 0xC3 on `s_prdata`.
- `req` = 1111 held; each owner drops `req` after one transfer → grant order 0,1,2,3,0, with exactly one `gnt` = 0 cycle between owners.
- Owner drops `req` during the setup phase of a transfer → `gnt` stays high through the access phase. RELEASE follows the cycle after `m_psel` falls.
- Assert `PRESET` in the middle of a transfer while `gnt` = 0100 → all outputs are 0 after that edge and `ptr` = 0.
- With `I2C_ARB_TIMEOUT_EN`, `TIMEOUT` = 16: owner holds `req` with no transfers → forced release after 16 idle cycles, `timeout_pulse` high for one cycle, next requester granted.
